// File: rtl/poly_eval_pkg.sv
// Shared types for the Horner polynomial evaluator.
// Optional overflow flag is enabled with POLY_EVAL_OVF_EN.
package poly_eval_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_LOAD        = 3'd0,
      S_LOAD_WAIT   = 3'd1,
      S_LOAD_X      = 3'd2,
      S_LOAD_X_WAIT = 3'd3,
      S_INIT        = 3'd4,
      S_MUL         = 3'd5,
      S_ADD         = 3'd6,
      S_DONE        = 3'd7
   } state_e;

   function automatic int idx_w(input int deg);
      return (deg < 1) ? 1 : $clog2(deg + 1);
   endfunction

endpackage

// File: rtl/poly_eval_if.sv
// Key/data/result bundle between the evaluator and its user.
// Overflow exists only when POLY_EVAL_OVF_EN is defined.
interface poly_eval_if #(
   parameter int WIDTH = 8
);
   logic             Go;
   logic [WIDTH-1:0] DataIn;
   logic [WIDTH-1:0] DataResult;
   logic             ResultValid;
   logic             Busy;
`ifdef POLY_EVAL_OVF_EN
   logic             Overflow;
`endif

   modport master (
      output Go, DataIn,
`ifdef POLY_EVAL_OVF_EN
      input  Overflow,
`endif
      input  DataResult, ResultValid, Busy
   );

   modport slave (
      input  Go, DataIn,
`ifdef POLY_EVAL_OVF_EN
      output Overflow,
`endif
      output DataResult, ResultValid, Busy
   );
endinterface

// File: rtl/poly_eval_datapath.sv
// Coefficient store, x, Horner accumulator and result register.
// Overflow tracking is built only when POLY_EVAL_OVF_EN is defined.
module poly_eval_datapath
   import poly_eval_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEGREE = 3,
   parameter int IW     = idx_w(DEGREE)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cap_coef_i,
   input  logic             cap_x_i,
   input  logic             init_i,
   input  logic             mul_i,
   input  logic             add_i,
   input  logic             ld_res_i,
   input  logic [IW-1:0]    idx_i,
   input  logic [IW-1:0]    k_i,
   input  logic [WIDTH-1:0] data_i,
`ifdef POLY_EVAL_OVF_EN
   output logic             ovf_o,
`endif
   output logic [WIDTH-1:0] result_o
);

   localparam logic [IW-1:0] DEG_I = IW'(DEGREE);

   logic [WIDTH-1:0] coef_q [DEGREE+1];
   logic [WIDTH-1:0] coef_d [DEGREE+1];
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [IW-1:0]    wr_idx;

   // Stored so that coef_q[i] holds a_i; entry order is a_DEGREE first.
   assign wr_idx = DEG_I - idx_i;

`ifdef POLY_EVAL_OVF_EN
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;
   logic               ovf_q, ovf_d;

   assign prod  = (2*WIDTH)'(acc_q) * (2*WIDTH)'(x_q);
   assign sum   = {1'b0, acc_q} + {1'b0, coef_q[k_i]};
   assign ovf_o = ovf_q;
`else
   logic [WIDTH-1:0] prod;
   logic [WIDTH-1:0] sum;

   assign prod = acc_q * x_q;
   assign sum  = acc_q + coef_q[k_i];
`endif

   always_comb begin
      coef_d = coef_q;
      x_d    = x_q;
      acc_d  = acc_q;
      res_d  = res_q;
`ifdef POLY_EVAL_OVF_EN
      ovf_d  = ovf_q;
`endif
      if (cap_coef_i) coef_d[wr_idx] = data_i;
      if (cap_x_i)    x_d = data_i;
      unique case (1'b1)
         init_i: begin
            acc_d = coef_q[DEG_I];
`ifdef POLY_EVAL_OVF_EN
            ovf_d = 1'b0;
`endif
         end
         mul_i: begin
            acc_d = prod[WIDTH-1:0];
`ifdef POLY_EVAL_OVF_EN
            ovf_d = ovf_q | (|prod[2*WIDTH-1:WIDTH]);
`endif
         end
         add_i: begin
            acc_d = sum[WIDTH-1:0];
            if (ld_res_i) res_d = sum[WIDTH-1:0];
`ifdef POLY_EVAL_OVF_EN
            ovf_d = ovf_q | sum[WIDTH];
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i <= DEGREE; i++) coef_q[i] <= '0;
         x_q   <= '0;
         acc_q <= '0;
         res_q <= '0;
`ifdef POLY_EVAL_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         coef_q <= coef_d;
         x_q    <= x_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
`ifdef POLY_EVAL_OVF_EN
         ovf_q  <= ovf_d;
`endif
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/poly_eval_fsm.sv
// Key-driven polynomial evaluator: load a_DEGREE..a_0 and x, then Horner.
// Optional sticky Overflow output is enabled with POLY_EVAL_OVF_EN.
module poly_eval_fsm
   import poly_eval_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEGREE = 3
) (
   input  logic      Clock,
   input  logic      Resetn,
   poly_eval_if.slave bus
);

   localparam int            IW    = idx_w(DEGREE);
   localparam logic [IW-1:0] DEG_I = IW'(DEGREE);
   localparam logic [IW-1:0] K_TOP = IW'(DEGREE - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] k_q, k_d;
   logic          cap_coef, cap_x, init, mul, add, ld_res;
   logic [WIDTH-1:0] result;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      k_d      = k_q;
      cap_coef = 1'b0;
      cap_x    = 1'b0;
      init     = 1'b0;
      mul      = 1'b0;
      add      = 1'b0;
      ld_res   = 1'b0;
      case (state_q)
         S_LOAD: if (bus.Go) begin
            cap_coef = 1'b1;
            state_d  = S_LOAD_WAIT;
         end
         S_LOAD_WAIT: if (!bus.Go) begin
            if (idx_q == DEG_I) begin
               state_d = S_LOAD_X;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD_X: if (bus.Go) begin
            cap_x   = 1'b1;
            state_d = S_LOAD_X_WAIT;
         end
         S_LOAD_X_WAIT: if (!bus.Go) state_d = S_INIT;
         S_INIT: begin
            init    = 1'b1;
            k_d     = K_TOP;
            state_d = S_MUL;
         end
         S_MUL: begin
            mul     = 1'b1;
            state_d = S_ADD;
         end
         S_ADD: begin
            add = 1'b1;
            if (k_q == '0) begin
               ld_res  = 1'b1;
               state_d = S_DONE;
            end else begin
               k_d     = k_q - 1'b1;
               state_d = S_MUL;
            end
         end
         // Coefficients stay; only x is replaced for re-evaluation.
         S_DONE: if (bus.Go) begin
            cap_x   = 1'b1;
            state_d = S_LOAD_X_WAIT;
         end
         default: begin
            state_d = S_LOAD;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_LOAD;
         idx_q   <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         k_q     <= k_d;
      end
   end

   poly_eval_datapath #(
      .WIDTH (WIDTH),
      .DEGREE(DEGREE),
      .IW    (IW)
   ) u_dp (
      .clk_i     (Clock),
      .rst_ni    (Resetn),
      .cap_coef_i(cap_coef),
      .cap_x_i   (cap_x),
      .init_i    (init),
      .mul_i     (mul),
      .add_i     (add),
      .ld_res_i  (ld_res),
      .idx_i     (idx_q),
      .k_i       (k_q),
      .data_i    (bus.DataIn),
`ifdef POLY_EVAL_OVF_EN
      .ovf_o     (bus.Overflow),
`endif
      .result_o  (result)
   );

   assign bus.DataResult  = result;
   assign bus.ResultValid = (state_q == S_DONE);
   assign bus.Busy        = (state_q == S_INIT) ||
                            (state_q == S_MUL)  ||
                            (state_q == S_ADD);

endmodule
